// File: rtl/mca_s_window_feeder_pkg.sv
// Shared types and default constants for the MCA window feeder and its
// decimation counter.
package mca_s_window_feeder_pkg;

  typedef enum logic [1:0] {FEED_FILL, FEED_IDLE, FEED_RUN} feeder_state_t;

  localparam int MCA_LATENCY_DEFAULT      = 4;
  localparam int DOWN_SAMPLE_RATE_DEFAULT = 8;

endpackage

// File: rtl/mca_decim_counter.sv
// Modulo-DOWN_SAMPLE_RATE counter of enabled cycles; hit flags the enabled
// cycle that completes each group.
module mca_decim_counter
  import mca_s_window_feeder_pkg::*;
#(
  parameter int DOWN_SAMPLE_RATE = DOWN_SAMPLE_RATE_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic hit
);
  localparam int CW = (DOWN_SAMPLE_RATE > 1) ? $clog2(DOWN_SAMPLE_RATE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DOWN_SAMPLE_RATE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    hit   = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = hit ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mca_s_window_feeder.sv
// Feeds the single-channel LUT3 FIR adder: shifts control bits into a K-bit
// window, snapshots it at each decimation point, and captures the adder result.
module mca_s_window_feeder
  import mca_s_window_feeder_pkg::*;
#(
  parameter int K                 = 256,
  parameter int DOWN_SAMPLE_RATE  = DOWN_SAMPLE_RATE_DEFAULT,
  parameter int MCA_LATENCY       = MCA_LATENCY_DEFAULT,
  parameter int WIDTH_COEFFICIENT = 32
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                s_in,
  input  logic                                s_valid,
  output logic [K-1:0]                        S_matrix,
  output logic                                start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] sample_in,
  output logic signed [WIDTH_COEFFICIENT-1:0] sample_out,
  output logic                                sample_valid,
  output logic                                overrun
);
  localparam int FW = $clog2(K + 1);
  localparam int LW = $clog2(MCA_LATENCY + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(K);
  localparam logic [FW-1:0] FILL_LAST = FW'(K - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(MCA_LATENCY - 1);

  logic [K-1:0]                        win_q, win_d;
  logic [K-1:0]                        s_matrix_q, s_matrix_d;
  logic [FW-1:0]                       fill_q, fill_d;
  logic [LW-1:0]                       lat_q, lat_d;
  feeder_state_t                       state_q, state_d;
  logic                                start_q, start_d;
  logic signed [WIDTH_COEFFICIENT-1:0] sample_q, sample_d;
  logic                                valid_q, valid_d;
  logic                                overrun_q, overrun_d;

  logic         dec_hit;
  logic         filled;
  logic         capture;
  logic         snapshot;
  logic [K-1:0] win_shift;

  mca_decim_counter #(
    .DOWN_SAMPLE_RATE(DOWN_SAMPLE_RATE)
  ) u_decim (
    .clk    (clk),
    .resetn (resetn),
    .en     (s_valid),
    .hit    (dec_hit)
  );

  // "filled" already counts the bit accepted on this edge.
  assign win_shift = {win_q[K-2:0], s_in};
  assign filled    = (fill_q == FILL_FULL) || (s_valid && (fill_q == FILL_LAST));
  assign capture   = (state_q == FEED_RUN) && !start_q && (lat_q == LAT_LAST);
  assign snapshot  = dec_hit && ((state_q == FEED_IDLE) || capture ||
                                 ((state_q == FEED_FILL) && filled));

  always_comb begin
    win_d      = win_q;
    fill_d     = fill_q;
    lat_d      = lat_q;
    state_d    = state_q;
    s_matrix_d = s_matrix_q;
    start_d    = 1'b0;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;

    if (s_valid) begin
      win_d = win_shift;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end
    end

    case (state_q)
      FEED_FILL: if (filled) state_d = FEED_IDLE;
      FEED_RUN: begin
        if (capture) begin
          sample_d = sample_in;
          valid_d  = 1'b1;
          state_d  = FEED_IDLE;
        end else begin
          if (!start_q) lat_d = lat_q + LW'(1);
          if (dec_hit) overrun_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A decimation point on the capture edge chains straight into a new run.
    if (snapshot) begin
      s_matrix_d = win_shift;
      start_d    = 1'b1;
      lat_d      = '0;
      state_d    = FEED_RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_q      <= '0;
      fill_q     <= '0;
      lat_q      <= '0;
      state_q    <= FEED_FILL;
      s_matrix_q <= '0;
      start_q    <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      win_q      <= win_d;
      fill_q     <= fill_d;
      lat_q      <= lat_d;
      state_q    <= state_d;
      s_matrix_q <= s_matrix_d;
      start_q    <= start_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign S_matrix     = s_matrix_q;
  assign start        = start_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mca_s_window_feeder.sv
// Scoreboard bench: two feeders (decimate-by-4 and an overrunning decimate-by-2)
// share one control stream and are checked against a bit-history reference model.
module tb_mca_s_window_feeder;
  localparam int K = 12;
  localparam int L = 3;
  localparam int W = 32;
  localparam int DSR_A = 4;
  localparam int DSR_B = 2;

  typedef struct {
    int           inst;
    int           cyc;
    logic [K-1:0] snap;
  } start_ev_t;

  typedef struct {
    int inst;
    int cyc;
    int val;
  } valid_ev_t;

  logic clk;
  logic resetn;
  logic s_in;
  logic s_valid;

  logic [K-1:0]        s_matrix_a, s_matrix_b;
  logic                start_a, start_b;
  logic signed [W-1:0] sample_in_a, sample_in_b;
  logic signed [W-1:0] sample_out_a, sample_out_b;
  logic                sample_valid_a, sample_valid_b;
  logic                overrun_a, overrun_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic         bit_hist[$];
  int           n_acc = 0;
  int           busy_cap[2] = '{-1, -1};
  logic         ovr[2] = '{1'b0, 1'b0};
  logic [K-1:0] last_snap[2] = '{'0, '0};
  int           held[2] = '{0, 0};
  start_ev_t    start_q[$];
  valid_ev_t    valid_q[$];
  logic [K-1:0] model_snap;
  logic         direct_mode = 1'b1;

  int pipe_a[3] = '{0, 0, 0};
  int pipe_b[3] = '{0, 0, 0};
  int t_start_a = -100;

  mca_s_window_feeder #(
    .K(K), .DOWN_SAMPLE_RATE(DSR_A), .MCA_LATENCY(L), .WIDTH_COEFFICIENT(W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_in         (s_in),
    .s_valid      (s_valid),
    .S_matrix     (s_matrix_a),
    .start        (start_a),
    .sample_in    (sample_in_a),
    .sample_out   (sample_out_a),
    .sample_valid (sample_valid_a),
    .overrun      (overrun_a)
  );

  mca_s_window_feeder #(
    .K(K), .DOWN_SAMPLE_RATE(DSR_B), .MCA_LATENCY(L), .WIDTH_COEFFICIENT(W)
  ) dut_ovr (
    .clk          (clk),
    .resetn       (resetn),
    .s_in         (s_in),
    .s_valid      (s_valid),
    .S_matrix     (s_matrix_b),
    .start        (start_b),
    .sample_in    (sample_in_b),
    .sample_out   (sample_out_b),
    .sample_valid (sample_valid_b),
    .overrun      (overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcount(input logic [K-1:0] v);
    int c = 0;
    for (int j = 0; j < K; j++) c += int'(v[j]);
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic bit_in);
    @(posedge clk);
    #1;
    s_valid = valid;
    s_in    = bit_in;
  endtask

  // Adder stand-ins: popcount of S_matrix three cycles later; in direct mode
  // feeder A only sees a meaningful value (7) exactly three cycles after start.
  always @(negedge clk) begin
    if (start_a) t_start_a = cyc;
    sample_in_a = direct_mode ? ((cyc == t_start_a + L) ? 32'sd7 : 32'shDEADBEEF) : W'(pipe_a[2]);
    sample_in_b = W'(pipe_b[2]);
    pipe_a[2] = pipe_a[1]; pipe_a[1] = pipe_a[0]; pipe_a[0] = popcount(s_matrix_a);
    pipe_b[2] = pipe_b[1]; pipe_b[1] = pipe_b[0]; pipe_b[0] = popcount(s_matrix_b);
  end

  // Reference model: history of accepted bits; every DSR-th accepted bit (once
  // K are in) either launches a transaction or, if one is in flight, an overrun.
  always @(posedge clk) begin
    if (resetn) begin
      if (s_valid) begin
        bit_hist.push_back(s_in);
        if (bit_hist.size() > K) void'(bit_hist.pop_front());
        n_acc++;
      end
      for (int i = 0; i < 2; i++) begin
        if (s_valid && n_acc >= K && (n_acc % ((i == 0) ? DSR_A : DSR_B)) == 0) begin
          if (busy_cap[i] > cyc) begin
            ovr[i] = 1'b1;
          end else begin
            start_ev_t se;
            valid_ev_t ve;
            for (int j = 0; j < K; j++) model_snap[j] = bit_hist[K - 1 - j];
            se.inst = i; se.cyc = cyc + 1; se.snap = model_snap;
            ve.inst = i; ve.cyc = cyc + 2 + L;
            ve.val  = (i == 0 && direct_mode) ? 7 : popcount(model_snap);
            start_q.push_back(se);
            valid_q.push_back(ve);
            busy_cap[i]  = cyc + 1 + L;
            last_snap[i] = model_snap;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge resetn) begin
    bit_hist.delete();
    start_q.delete();
    valid_q.delete();
    n_acc = 0;
    for (int i = 0; i < 2; i++) begin
      busy_cap[i]  = -1;
      ovr[i]       = 1'b0;
      last_snap[i] = '0;
      held[i]      = 0;
    end
  end

  task automatic monitorInst(input int i, input logic st, input logic [K-1:0] sm, input logic sv,
                             input logic signed [W-1:0] so, input logic ov);
    int sidx = -1;
    int vidx = -1;
    foreach (start_q[j]) if (sidx < 0 && start_q[j].inst == i) sidx = j;
    foreach (valid_q[j]) if (vidx < 0 && valid_q[j].inst == i) vidx = j;
    if (sidx >= 0 && start_q[sidx].cyc == cyc) begin
      checkOutput((i == 0) ? "start_a" : "start_b", 64'(st), 64'd1);
      checkOutput((i == 0) ? "snap_a" : "snap_b", 64'(sm), 64'(start_q[sidx].snap));
      start_q.delete(sidx);
    end else begin
      checkOutput((i == 0) ? "start_a_idle" : "start_b_idle", 64'(st), 64'd0);
    end
    if (vidx >= 0 && valid_q[vidx].cyc == cyc) begin
      checkOutput((i == 0) ? "valid_a" : "valid_b", 64'(sv), 64'd1);
      held[i] = valid_q[vidx].val;
      valid_q.delete(vidx);
    end else begin
      checkOutput((i == 0) ? "valid_a_idle" : "valid_b_idle", 64'(sv), 64'd0);
    end
    checkOutput((i == 0) ? "sample_out_a" : "sample_out_b", 64'(so), 64'(held[i]));
    checkOutput((i == 0) ? "s_matrix_a" : "s_matrix_b", 64'(sm), 64'(last_snap[i]));
    checkOutput((i == 0) ? "overrun_a" : "overrun_b", 64'(ov), 64'(ovr[i]));
  endtask

  always @(negedge clk) begin
    monitorInst(0, start_a, s_matrix_a, sample_valid_a, sample_out_a, overrun_a);
    monitorInst(1, start_b, s_matrix_b, sample_valid_b, sample_out_b, overrun_b);
  end

  initial begin
    logic [K-1:0] fill_seq;
    logic         found;
    fill_seq = 12'b1011_0010_1110;
    resetn = 1'b0; s_valid = 1'b0; s_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    $display("[TB] fill and latency");
    for (int j = 0; j < K; j++) applyStimulus(1'b1, fill_seq[K - 1 - j]);
    repeat (8) applyStimulus(1'b0, 1'b0);
    checkOutput("latency_sample_a", 64'(sample_out_a), 64'd7);
    direct_mode = 1'b0;

    $display("[TB] continuous stream");
    repeat (40) applyStimulus(1'b1, 1'b1);
    checkOutput("cont_snap_all_ones", 64'(s_matrix_a), 64'hFFF);
    checkOutput("cont_no_overrun_a", 64'(overrun_a), 64'd0);
    checkOutput("overrun_b_sticky", 64'(overrun_b), 64'd1);

    $display("[TB] random stream with gaps");
    repeat (300) applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

    $display("[TB] reset mid-run");
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (start_a) found = 1'b1;
    end
    checkOutput("reset_wait_start", 64'(found), 64'd1);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    checkOutput("rst_start", 64'(start_a), 64'd0);
    checkOutput("rst_valid", 64'(sample_valid_a), 64'd0);
    checkOutput("rst_sample_out", 64'(sample_out_a), 64'd0);
    checkOutput("rst_overrun_b", 64'(overrun_b), 64'd0);
    repeat (3) applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (200) applyStimulus($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));

    repeat (12) applyStimulus(1'b0, 1'b0);
    checkOutput("drain_start_q", 64'(start_q.size()), 64'd0);
    checkOutput("drain_valid_q", 64'(valid_q.size()), 64'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
